// File: rtl/swivm_intc.sv
// Prioritised, maskable interrupt controller with interval timer for the Swieros VM CPU.
// Offers the lowest pending+enabled channel with its trap value and holds it until acknowledged.
module swivm_intc #(
  parameter int NUM_IRQ     = 4,
  parameter int TIMER_W     = 32,
  parameter int TRAP_BASE   = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic               i_wr_en,
  input  logic [1:0]         i_sel,
  input  logic [31:0]        i_wr_data,
  output logic [31:0]        o_rd_data,
  output logic               o_irq_req,
  output logic [4:0]         o_trapval,
  input  logic               i_ack
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] OFFER = 1'b1;

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] edge_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] mask;
  logic [NUM_IRQ-1:0] pending;
  logic [NUM_IRQ-1:0] hw_set, sw_set, clr;
  logic [NUM_IRQ-1:0] cand, pick, offer_vec;
  logic [TIMER_W-1:0] timeout, count;
  logic               timer_on, tick;
  logic               wr_mask, wr_timeout, wr_pclr, wr_pset;
  logic               found;
  logic [4:0]         pick_idx;
  logic [0:0]         state;
  logic               unused_wr_data;

  assign unused_wr_data = ^i_wr_data;

  assign wr_mask    = i_wr_en && (i_sel == 2'd0);
  assign wr_timeout = i_wr_en && (i_sel == 2'd1);
  assign wr_pclr    = i_wr_en && (i_sel == 2'd2);
  assign wr_pset    = i_wr_en && (i_sel == 2'd3);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      edge_q <= '0;
    end else begin
      sync_q[0] <= i_irq;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      edge_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~edge_q;

  assign timer_on = (timeout != '0);
  assign tick     = timer_on && (count == timeout - TIMER_W'(1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timeout <= '0;
      count   <= '0;
      mask    <= '0;
    end else begin
      if (wr_timeout) timeout <= i_wr_data[TIMER_W-1:0];
      if (wr_mask)    mask    <= i_wr_data[NUM_IRQ-1:0];
      if (wr_timeout || !timer_on || tick) count <= '0;
      else                                 count <= count + TIMER_W'(1);
    end
  end

  // Sets are OR-ed in after clears so a coincident hardware or software set always survives.
  assign hw_set = rise | NUM_IRQ'(tick);
  assign sw_set = wr_pset ? i_wr_data[NUM_IRQ-1:0] : '0;
  assign clr    = (wr_pclr ? i_wr_data[NUM_IRQ-1:0] : '0) |
                  (((state == OFFER) && i_ack) ? offer_vec : '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) pending <= '0;
    else          pending <= (pending & ~clr) | sw_set | hw_set;
  end

  assign cand = pending & mask;

  always_comb begin
    found    = 1'b0;
    pick     = '0;
    pick_idx = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (!found && cand[i]) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = 5'(i);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      o_irq_req <= 1'b0;
      o_trapval <= '0;
      offer_vec <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            offer_vec <= pick;
            o_trapval <= 5'(TRAP_BASE) + pick_idx;
            o_irq_req <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (i_ack) begin
            o_irq_req <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          o_irq_req <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_rd_data <= '0;
    end else begin
      case (i_sel)
        2'd0:    o_rd_data <= 32'(mask);
        2'd1:    o_rd_data <= 32'(timeout);
        2'd2:    o_rd_data <= 32'(pending);
        default: o_rd_data <= 32'(count);
      endcase
    end
  end

endmodule

// File: tb/tb_swivm_intc.sv
// Scoreboard bench for swivm_intc: expected trap values and readbacks are queued with stimulus.
module tb_swivm_intc;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [3:0]  i_irq = '0;
  logic        i_wr_en = 1'b0;
  logic [1:0]  i_sel = '0;
  logic [31:0] i_wr_data = '0;
  logic [31:0] o_rd_data;
  logic        o_irq_req;
  logic [4:0]  o_trapval;
  logic        i_ack = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int t_rise = 0;
  logic [31:0] exp_q[$];

  swivm_intc #(.NUM_IRQ(4), .TIMER_W(32), .TRAP_BASE(1), .SYNC_STAGES(2)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_irq(i_irq), .i_wr_en(i_wr_en),
    .i_sel(i_sel), .i_wr_data(i_wr_data), .o_rd_data(o_rd_data),
    .o_irq_req(o_irq_req), .o_trapval(o_trapval), .i_ack(i_ack)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] got);
    logic [31:0] e;
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hFFFF_FFFF;
    check(tag, got, e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    i_wr_en = 1'b1; i_sel = sel; i_wr_data = data;
    tick(1);
    i_wr_en = 1'b0; i_wr_data = '0;
  endtask

  task automatic rd(input string tag, input logic [1:0] sel, input logic [31:0] exp);
    i_sel = sel;
    tick(1);
    check(tag, o_rd_data, exp);
  endtask

  task automatic wait_req(input int budget);
    for (int i = 0; i < budget && !o_irq_req; i++) tick(1);
    check("req_wait", {31'b0, o_irq_req}, 32'd1);
    t_rise = cyc;
  endtask

  task automatic ack();
    i_ack = 1'b1;
    tick(1);
    i_ack = 1'b0;
    check("ack_drop", {31'b0, o_irq_req}, 32'd0);
  endtask

  initial begin
    // Reset and idle
    tick(3);
    check("rst_req", {31'b0, o_irq_req}, 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("idle_req", {31'b0, o_irq_req}, 32'd0);
      check("idle_tv", o_trapval, 32'd0);
      check("idle_rd", o_rd_data, 32'd0);
    end

    // Single external channel, latency and held level
    wr(2'd0, 32'h2);
    i_sel = 2'd2;
    push(32'd2);
    i_irq[1] = 1'b1;
    tick(3);
    check("lat_req_early", {31'b0, o_irq_req}, 32'd0);
    check("lat_pend_early", o_rd_data, 32'd0);
    tick(1);
    check("lat_pend", o_rd_data, 32'h2);
    check("lat_req", {31'b0, o_irq_req}, 32'd1);
    pop_check("ch1_tv", o_trapval);
    ack();
    tick(1);
    check("ch1_pend_clr", o_rd_data, 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("held_no_reoffer", {31'b0, o_irq_req}, 32'd0);
    end
    i_irq[1] = 1'b0;
    tick(4);

    // Interval timer
    wr(2'd0, 32'h1);
    wr(2'd1, 32'd5);
    i_sel = 2'd3;
    push(32'd0); push(32'd1); push(32'd2); push(32'd3); push(32'd4); push(32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      pop_check("count", o_rd_data);
    end
    push(32'd1);
    check("tmr_req", {31'b0, o_irq_req}, 32'd1);
    pop_check("tmr_tv", o_trapval);
    t_rise = cyc;
    for (int p = 0; p < 3; p++) begin
      int prev;
      prev = t_rise;
      push(32'd1);
      ack();
      wait_req(10);
      check("tmr_period", t_rise - prev, 32'd5);
      pop_check("tmr_tv", o_trapval);
    end
    ack();
    wr(2'd1, 32'd0);
    for (int i = 0; i < 20; i++) begin
      tick(1);
      check("tmr_off", {31'b0, o_irq_req}, 32'd0);
    end
    rd("tmr_off_count", 2'd3, 32'd0);
    rd("tmr_off_pend", 2'd2, 32'd0);

    // Fixed priority, offer held while a higher channel arrives
    wr(2'd0, 32'hF);
    push(32'd3); push(32'd1); push(32'd4);
    wr(2'd3, 32'hC);
    wait_req(5);
    pop_check("prio_first", o_trapval);
    i_irq[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("hold_req", {31'b0, o_irq_req}, 32'd1);
      check("hold_tv", o_trapval, 32'd3);
    end
    ack();
    wait_req(5);
    pop_check("prio_second", o_trapval);
    ack();
    wait_req(5);
    pop_check("prio_third", o_trapval);
    ack();
    i_irq[0] = 1'b0;
    rd("prio_pend_clr", 2'd2, 32'd0);
    tick(3);

    // Edge arriving on the same cycle as ack must survive
    push(32'd3); push(32'd3);
    wr(2'd3, 32'h4);
    wait_req(5);
    pop_check("race_first", o_trapval);
    i_irq[2] = 1'b1;
    tick(2);
    i_ack = 1'b1;
    i_sel = 2'd2;
    tick(1);
    i_ack = 1'b0;
    check("race_gap", {31'b0, o_irq_req}, 32'd0);
    tick(1);
    check("race_pend", o_rd_data, 32'h4);
    check("race_reoffer", {31'b0, o_irq_req}, 32'd1);
    pop_check("race_tv", o_trapval);
    ack();
    i_irq[2] = 1'b0;
    rd("race_pend_clr", 2'd2, 32'd0);

    // Async reset mid-offer
    wr(2'd3, 32'h2);
    wait_req(5);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("arst_req", {31'b0, o_irq_req}, 32'd0);
    check("arst_tv", o_trapval, 32'd0);
    tick(1);
    i_rst_n = 1'b1;
    rd("arst_mask", 2'd0, 32'd0);
    rd("arst_timeout", 2'd1, 32'd0);
    rd("arst_pend", 2'd2, 32'd0);
    rd("arst_count", 2'd3, 32'd0);
    check("arst_req_after", {31'b0, o_irq_req}, 32'd0);

    check("sb_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
